cp0_reg: RTL

- Coprocessor-0 register file for the 5-stage MIPS core.
- Services the CP0 interface driven by the memory stage: mtc0 writes, exception type, delay-slot flag and faulting instruction address.
- Returns Status, Cause and EPC to the memory stage for exception detection and ERET targets.
- Holds the free-running Count/Compare timer and samples external interrupts into Cause.IP.

---
 rtl/cp0_reg_pkg.sv | 42 ++++
 rtl/cp0_reg_if.sv | 33 +++
 rtl/cp0_timer.sv | 29 ++
 rtl/cp0_reg.sv | 113 +++++++++++
 4 files changed

// File: rtl/cp0_reg_pkg.sv
// CP0 register addresses, exception type/code encodings and Status/Cause bit
// positions shared by the CP0 register file and its timer.
package cp0_reg_pkg;
  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;
  localparam logic [4:0] CP0_CONFIG  = 5'd16;

  localparam logic [31:0] EXC_INT  = 32'h1;
  localparam logic [31:0] EXC_SYS  = 32'h8;
  localparam logic [31:0] EXC_RI   = 32'ha;
  localparam logic [31:0] EXC_OV   = 32'hc;
  localparam logic [31:0] EXC_TRAP = 32'hd;
  localparam logic [31:0] EXC_ERET = 32'he;

  localparam logic [4:0] EXCCODE_INT  = 5'd0;
  localparam logic [4:0] EXCCODE_SYS  = 5'd8;
  localparam logic [4:0] EXCCODE_RI   = 5'd10;
  localparam logic [4:0] EXCCODE_OV   = 5'd12;
  localparam logic [4:0] EXCCODE_TRAP = 5'd13;

  localparam int ST_EXL = 1;
  localparam int CA_BD  = 31;
  localparam int CA_IV  = 23;
  localparam int CA_WP  = 22;

  localparam logic [31:0] STATUS_RST = 32'h10000000;

  // Maps a synchronous exception type to its Cause.ExcCode.
  function automatic logic [4:0] exc_code(input logic [31:0] t);
    case (t)
      EXC_SYS:  return EXCCODE_SYS;
      EXC_RI:   return EXCCODE_RI;
      EXC_OV:   return EXCCODE_OV;
      EXC_TRAP: return EXCCODE_TRAP;
      default:  return EXCCODE_INT;
    endcase
  endfunction
endpackage

// File: rtl/cp0_reg_if.sv
// CP0 access bus between the pipeline (master) and the CP0 register file (slave).
interface cp0_reg_if;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [4:0]  raddr_i;
  logic [31:0] data_i;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] data_o;
  logic [31:0] count_o;
  logic [31:0] compare_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] config_o;
  logic [31:0] prid_o;
  logic        timer_int_o;

  modport master (
    output we_i, waddr_i, raddr_i, data_i, int_i, excepttype_i,
           current_inst_addr_i, is_in_delayslot_i,
    input  data_o, count_o, compare_o, status_o, cause_o, epc_o,
           config_o, prid_o, timer_int_o
  );
  modport slave (
    input  we_i, waddr_i, raddr_i, data_i, int_i, excepttype_i,
           current_inst_addr_i, is_in_delayslot_i,
    output data_o, count_o, compare_o, status_o, cause_o, epc_o,
           config_o, prid_o, timer_int_o
  );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare pair with a sticky timer interrupt raised on Count == Compare.
module cp0_timer
  import cp0_reg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      compare   <= '0;
      timer_int <= 1'b0;
    end else begin
      count <= (we && waddr == CP0_COUNT) ? wdata : count + 32'd1;
      if (we && waddr == CP0_COMPARE) begin
        compare   <= wdata;
        timer_int <= 1'b0;
      end else if (compare != '0 && count == compare) begin
        timer_int <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/cp0_reg.sv
// CP0 register file: Count/Compare, Status, Cause, EPC, PRId, Config.
// Define CP0_TIMER_INT_EN to enable the Count==Compare timer interrupt.
module cp0_reg
  import cp0_reg_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE   = 32'h00480102,
  parameter logic [31:0] CONFIG_VALUE = 32'h00008000
) (
  input  logic      clk,
  input  logic      rst,
  cp0_reg_if.slave  cp0
);
  logic [31:0] count_q, compare_q, status_q, cause_q, epc_q;
  logic        timer_int;
  logic [31:0] exc_epc;

`ifdef CP0_TIMER_INT_EN
  cp0_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .we        (cp0.we_i),
    .waddr     (cp0.waddr_i),
    .wdata     (cp0.data_i),
    .count     (count_q),
    .compare   (compare_q),
    .timer_int (timer_int)
  );
`else
  assign timer_int = 1'b0;
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= '0;
    end else begin
      count_q <= (cp0.we_i && cp0.waddr_i == CP0_COUNT) ? cp0.data_i : count_q + 32'd1;
      if (cp0.we_i && cp0.waddr_i == CP0_COMPARE) compare_q <= cp0.data_i;
    end
  end
`endif

  // A delay-slot fault restarts at the branch, one word earlier.
  assign exc_epc = cp0.is_in_delayslot_i ? cp0.current_inst_addr_i - 32'd4
                                         : cp0.current_inst_addr_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= STATUS_RST;
      cause_q  <= '0;
      epc_q    <= '0;
    end else begin
      cause_q[15:10] <= {cp0.int_i[5] | timer_int, cp0.int_i[4:0]};
      // Any nonzero excepttype blocks mtc0 into Status/Cause/EPC this cycle.
      if (cp0.excepttype_i == '0) begin
        if (cp0.we_i) begin
          case (cp0.waddr_i)
            CP0_STATUS: status_q <= cp0.data_i;
            CP0_EPC:    epc_q    <= cp0.data_i;
            CP0_CAUSE: begin
              cause_q[9:8]   <= cp0.data_i[9:8];
              cause_q[CA_WP] <= cp0.data_i[CA_WP];
              cause_q[CA_IV] <= cp0.data_i[CA_IV];
            end
            default: ;
          endcase
        end
      end else begin
        case (cp0.excepttype_i)
          EXC_INT: begin
            epc_q            <= exc_epc;
            cause_q[CA_BD]   <= cp0.is_in_delayslot_i;
            status_q[ST_EXL] <= 1'b1;
            cause_q[6:2]     <= EXCCODE_INT;
          end
          EXC_SYS, EXC_RI, EXC_OV, EXC_TRAP: begin
            if (!status_q[ST_EXL]) begin
              epc_q          <= exc_epc;
              cause_q[CA_BD] <= cp0.is_in_delayslot_i;
            end
            status_q[ST_EXL] <= 1'b1;
            cause_q[6:2]     <= exc_code(cp0.excepttype_i);
          end
          EXC_ERET: status_q[ST_EXL] <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    cp0.data_o = '0;
    if (!rst) begin
      case (cp0.raddr_i)
        CP0_COUNT:   cp0.data_o = count_q;
        CP0_COMPARE: cp0.data_o = compare_q;
        CP0_STATUS:  cp0.data_o = status_q;
        CP0_CAUSE:   cp0.data_o = cause_q;
        CP0_EPC:     cp0.data_o = epc_q;
        CP0_PRID:    cp0.data_o = PRID_VALUE;
        CP0_CONFIG:  cp0.data_o = CONFIG_VALUE;
        default:     cp0.data_o = '0;
      endcase
    end
  end

  assign cp0.count_o     = count_q;
  assign cp0.compare_o   = compare_q;
  assign cp0.status_o    = status_q;
  assign cp0.cause_o     = cause_q;
  assign cp0.epc_o       = epc_q;
  assign cp0.config_o    = CONFIG_VALUE;
  assign cp0.prid_o      = PRID_VALUE;
  assign cp0.timer_int_o = timer_int;
endmodule
